// File: rtl/div_dispatch_pkg.sv
// Shared types and encodings for the divider dispatch block.
package div_dispatch_pkg;

  localparam int DATA_W_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_DVZ = 2'b01;
  localparam logic [1:0] ST_OVF = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

endpackage

// File: rtl/div_opfifo.sv
// Operand-pair FIFO: power-of-two depth, wrapping pointers, explicit occupancy count.
module div_opfifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/div_dispatch.sv
// Queues operand pairs and issues them one at a time to a multicycle divider,
// returning quotient plus status (ok / divide-by-zero / overflow / timeout).
module div_dispatch
  import div_dispatch_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic              div_valid,
  input  logic              div_dvz,
  input  logic              div_ovf,
  input  logic [DATA_W-1:0] div_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_q,
  output logic [1:0]        out_status
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d, timer_inc;
  logic                dvz_q, dvz_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, q_q, q_d;
  logic [1:0]          st_q, st_d;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [2*DATA_W-1:0] fifo_dout;

  assign in_ready   = !fifo_full;
  assign fifo_pop   = (state_q == S_ISSUE);
  assign div_start  = (state_q == S_ISSUE);
  assign out_valid  = (state_q == S_HOLD);
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign out_q      = q_q;
  assign out_status = st_q;
  assign timer_inc  = timer_q + 1'b1;

  div_opfifo #(.W(2*DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .sclr  (sclr),
    .push  (in_valid && in_ready),
    .din   ({in_a, in_b}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dvz_d   = dvz_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    st_d    = st_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE: begin
        {a_d, b_d} = fifo_dout;
        dvz_d      = 1'b0;
        timer_d    = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (div_dvz) dvz_d = 1'b1;
        // Completion beats timeout; ovf beats a simultaneous normal completion.
        if (div_ovf) begin
          q_d     = div_q;
          st_d    = ST_OVF;
          state_d = S_HOLD;
        end else if (div_valid) begin
          q_d     = div_q;
          st_d    = (dvz_q || div_dvz) ? ST_DVZ : ST_OK;
          state_d = S_HOLD;
        end else if (timer_inc == TW'(TIMEOUT)) begin
          q_d     = '0;
          st_d    = ST_TMO;
          state_d = S_HOLD;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_HOLD: if (out_ready) state_d = fifo_empty ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      dvz_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      st_q    <= ST_OK;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dvz_q   <= dvz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      st_q    <= st_d;
    end
  end

endmodule

// File: tb/tb_div_dispatch.sv
// Scoreboard bench for div_dispatch with a behavioural divider BFM.
module tb_div_dispatch;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          sclr = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic          div_start;
  logic [DW-1:0] div_a, div_b;
  logic          div_valid, div_dvz, div_ovf;
  logic [DW-1:0] div_q;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_q;
  logic [1:0]    out_status;

  div_dispatch #(.DATA_W(DW), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .sclr(sclr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_valid(div_valid), .div_dvz(div_dvz), .div_ovf(div_ovf), .div_q(div_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_status(out_status)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected {status, q} in push order.
  logic [DW+1:0] exp_q[$];

  // BFM behaviour per issued op: 0 normal, 1 dvz then valid, 2 valid+ovf, 3 never completes.
  int bm_mode[64];
  int bm_lat[64];
  int bm_wr = 0;
  logic spur = 1'b0;

  int bfm_rd = 0, n_starts = 0, start_cyc = 0;
  int cur_mode = 0, cur_lat = 0, cnt = 0;
  bit busy = 0;

  initial begin
    div_valid = 0; div_dvz = 0; div_ovf = 0; div_q = '0;
    forever begin
      @(negedge clk);
      div_valid = 0; div_dvz = 0; div_ovf = 0;
      if (sclr) begin
        busy = 0;
        bfm_rd = bm_wr;
      end else begin
        if (spur) begin div_valid = 1; div_q = 10'd123; end
        if (busy) begin
          cnt++;
          if (cur_mode == 1 && cnt == 2) div_dvz = 1;
          if (cnt == cur_lat) begin
            busy = 0;
            div_q = (div_b == 0 || cur_mode == 2) ? '1 : div_a / div_b;
            div_valid = 1;
            if (cur_mode == 2) div_ovf = 1;
          end
        end else if (div_start) begin
          n_starts++;
          start_cyc = cyc;
          cur_mode = bm_mode[bfm_rd % 64];
          cur_lat  = (cur_mode == 1) ? 17 : bm_lat[bfm_rd % 64];
          bfm_rd++;
          cnt = 0;
          busy = (cur_mode != 3);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input int mode, input int lat);
    logic [DW-1:0] q;
    logic [1:0] st;
    int k;
    bm_mode[bm_wr % 64] = mode;
    bm_lat[bm_wr % 64]  = lat;
    bm_wr++;
    case (mode)
      0:       begin q = a / b; st = 2'b00; end
      1:       begin q = '1;    st = 2'b01; end
      2:       begin q = '1;    st = 2'b10; end
      default: begin q = '0;    st = 2'b11; end
    endcase
    exp_q.push_back({st, q});
    @(negedge clk);
    in_valid = 1; in_a = a; in_b = b;
    k = 0;
    while (!in_ready && k < 300) begin @(negedge clk); k++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL push_accept: in_ready=%0b required 1 within 300 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain(input int n);
    logic [DW+1:0] e, got;
    int k;
    out_ready = 1;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!out_valid && k < 300) begin @(negedge clk); k++; end
      n_cmp++;
      if (!out_valid) begin
        n_bad++;
        $display("FAIL result_wait: out_valid=0 required 1 within 300 cycles");
        out_ready = 0;
        return;
      end
      got = {out_status, out_q};
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL result_extra: got st=%b q=%0d with nothing expected", got[DW+1:DW], got[DW-1:0]);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL result: st=%b q=%0d required st=%b q=%0d", got[DW+1:DW], got[DW-1:0], e[DW+1:DW], e[DW-1:0]);
        end
      end
      @(negedge clk);
    end
    out_ready = 0;
  endtask

  task automatic test_reset();
    sclr = 1;
    repeat (3) @(negedge clk);
    sclr = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: %b required 1", in_ready); end
    n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL rst_div_start: %b required 0", div_start); end
    n_cmp++; if (out_q !== '0) begin n_bad++; $display("FAIL rst_out_q: %0d required 0", out_q); end
    n_cmp++; if (out_status !== 2'b00) begin n_bad++; $display("FAIL rst_status: %b required 00", out_status); end
    n_cmp++; if ({div_a, div_b} !== '0) begin n_bad++; $display("FAIL rst_div_ab: a=%0d b=%0d required 0 0", div_a, div_b); end
  endtask

  task automatic test_single();
    int s = n_starts;
    push(100, 7, 0, 20);
    drain(1);
    n_cmp++; if (n_starts - s != 1) begin n_bad++; $display("FAIL single_starts: %0d required 1", n_starts - s); end
  endtask

  task automatic test_dvz();
    int k = 0;
    push(55, 0, 1, 17);
    while (k < 100) begin
      @(negedge clk); #1;
      if (div_dvz) break;
      k++;
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dvz_early_exit: out_valid=%b required 0", out_valid); end
    drain(1);
  endtask

  task automatic test_ovf();
    push(300, 1, 2, 5);
    drain(1);
  endtask

  task automatic test_spurious();
    int s = n_starts;
    @(negedge clk); spur = 1;
    @(negedge clk); spur = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL spurious_out_valid: %b required 0", out_valid); end
    n_cmp++; if (n_starts != s) begin n_bad++; $display("FAIL spurious_start: %0d starts required 0", n_starts - s); end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] q0;
    logic [1:0] s0;
    int k = 0;
    out_ready = 0;
    push(200, 3, 0, 4);
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    q0 = out_q; s0 = out_status;
    push(90, 9, 0, 6);
    push(81, 4, 0, 6);
    push(1023, 2, 0, 6);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_before_full: %b required 1", in_ready); end
    push(17, 5, 0, 6);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: %b required 0", in_ready); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_q !== 10'd66 || out_status !== s0 || out_q !== q0) begin
      n_bad++;
      $display("FAIL bp_hold_stable: valid=%b q=%0d st=%b required 1 66 00", out_valid, out_q, out_status);
    end
    drain(5);
  endtask

  task automatic test_timeout();
    int k = 0;
    int s = n_starts;
    push(50, 5, 3, 0);
    push(60, 6, 0, 3);
    while (!out_valid && k < 200) begin @(negedge clk); k++; end
    n_cmp++; if (cyc - start_cyc != 65) begin n_bad++; $display("FAIL tmo_latency: %0d required 65", cyc - start_cyc); end
    drain(2);
    n_cmp++; if (n_starts - s != 2) begin n_bad++; $display("FAIL tmo_next_issue: %0d starts required 2", n_starts - s); end
  endtask

  task automatic test_reset_midwait();
    int s;
    push(10, 2, 3, 0);
    push(20, 2, 3, 0);
    push(30, 2, 3, 0);
    repeat (5) @(negedge clk);
    sclr = 1;
    @(negedge clk);
    exp_q.delete();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid: %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready: %b required 1", in_ready); end
    sclr = 0;
    s = n_starts;
    repeat (10) @(negedge clk);
    n_cmp++; if (n_starts != s) begin n_bad++; $display("FAIL mid_rst_no_issue: %0d starts required 0", n_starts - s); end
    push(77, 7, 0, 4);
    drain(1);
    n_cmp++; if (n_starts - s != 1) begin n_bad++; $display("FAIL mid_rst_new_issue: %0d starts required 1", n_starts - s); end
  endtask

  task automatic test_back_to_back();
    push(999, 10, 0, 1);
    push(13, 13, 0, 2);
    push(0, 5, 0, 1);
    push(511, 1, 2, 3);
    drain(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_dvz();
    test_ovf();
    test_spurious();
    test_back_pressure();
    test_timeout();
    test_reset_midwait();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL leftover_results: %0d pending required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
